assume_r4_mult: RTL and testbench

ASSUME_R4_MULT -- requirements
Module: assume_r4_mult

---
 rtl/assume_r4_pkg.sv | 25 ++
 rtl/booth_r4_pp.sv | 20 ++
 rtl/assume_r4_mult.sv | 125 ++++++++++++
 tb/tb_assume_r4_mult.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/assume_r4_pkg.sv
// Shared constants and state type for the byte-serial radix-4 Booth multiplier.
// ASSUME_R4_SIGNED_EN selects two's-complement operands; the default build multiplies unsigned.
package assume_r4_pkg;

  localparam int IN_W  = 8;
  localparam int OP_W  = 16;
  localparam int RES_W = 32;

  // Unsigned X needs a ninth digit so its top bit is never read as a sign.
`ifdef ASSUME_R4_SIGNED_EN
  localparam bit SIGNED_OPS = 1'b1;
  localparam int DIGITS     = 8;
  localparam int PP_W       = 18;
`else
  localparam bit SIGNED_OPS = 1'b0;
  localparam int DIGITS     = 9;
  localparam int PP_W       = 19;
`endif

  localparam int XS_W  = 2 * DIGITS;
  localparam int ACC_W = PP_W + XS_W;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

endpackage

// File: rtl/booth_r4_pp.sv
// Radix-4 Booth digit decode: maps an overlapping 3-bit group of X onto 0, +-A or +-2A.
module booth_r4_pp #(
  parameter int W = 18
) (
  input  logic [2:0]          grp,
  input  logic signed [W-1:0] a,
  output logic signed [W-1:0] pp
);

  always_comb begin
    case (grp)
      3'b001, 3'b010: pp = a;
      3'b011:         pp = a <<< 1;
      3'b100:         pp = -(a <<< 1);
      3'b101, 3'b110: pp = -a;
      default:        pp = '0;
    endcase
  end

endmodule

// File: rtl/assume_r4_mult.sv
// Byte-serial radix-4 Booth multiplier: A and X arrive a byte at a time, one Booth digit retires per cycle.
// Define ASSUME_R4_SIGNED_EN for two's-complement operands; the default build multiplies unsigned.
module assume_r4_mult #(
  parameter int IN_W  = assume_r4_pkg::IN_W,
  parameter int OP_W  = assume_r4_pkg::OP_W,
  parameter int RES_W = assume_r4_pkg::RES_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             getA,
  input  logic             getX,
  input  logic [IN_W-1:0]  in,
  output logic [RES_W-1:0] result,
  output logic             ready
);
  import assume_r4_pkg::*;

  localparam logic [3:0] LAST_CNT = 4'(DIGITS - 1);

  state_t                  state, state_nxt;
  logic [OP_W-1:0]         a, x;
  logic [1:0]              aptr, xptr;
  logic                    geta_q, getx_q;
  logic                    rise_a, rise_x, ops_full;
  logic signed [ACC_W-1:0] acc, acc_sum, acc_step;
  logic [XS_W-1:0]         xs;
  logic                    xprev;
  logic [3:0]              cnt;
  logic signed [PP_W-1:0]  a_ext, pp;

  assign rise_a   = getA & ~geta_q;
  assign rise_x   = getX & ~getx_q;
  assign ops_full = (aptr == 2'd2) && (xptr == 2'd2);

  always_comb begin
    if (SIGNED_OPS) a_ext = {{(PP_W - OP_W){a[OP_W-1]}}, a};
    else            a_ext = {{(PP_W - OP_W){1'b0}}, a};
  end

  booth_r4_pp #(.W(PP_W)) u_pp (
    .grp ({xs[1:0], xprev}),
    .a   (a_ext),
    .pp  (pp)
  );

  // Partial products enter at the top; shifting right by 2 each digit lands the final sum at bit 0.
  assign acc_sum  = acc + {pp, {XS_W{1'b0}}};
  assign acc_step = acc_sum >>> 2;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD:    if (ops_full) state_nxt = CALC;
        CALC:    if (cnt == LAST_CNT) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    ready  = (state == DONE);
    result = ready ? acc[RES_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a      <= '0;
      x      <= '0;
      aptr   <= '0;
      xptr   <= '0;
      geta_q <= 1'b0;
      getx_q <= 1'b0;
      acc    <= '0;
      xs     <= '0;
      xprev  <= 1'b0;
      cnt    <= '0;
    end else begin
      geta_q <= getA;
      getx_q <= getX;
      if (start) begin
        a     <= '0;
        x     <= '0;
        aptr  <= '0;
        xptr  <= '0;
        acc   <= '0;
        xs    <= '0;
        xprev <= 1'b0;
        cnt   <= '0;
      end else if (state == LOAD) begin
        if (rise_a && aptr != 2'd2) begin
          if (aptr == 2'd0) a[IN_W-1:0]    <= in;
          else              a[OP_W-1:IN_W] <= in;
          aptr <= aptr + 2'd1;
        end
        if (rise_x && xptr != 2'd2) begin
          if (xptr == 2'd0) x[IN_W-1:0]    <= in;
          else              x[OP_W-1:IN_W] <= in;
          xptr <= xptr + 2'd1;
        end
        // X is zero-extended into the digit shifter; for unsigned operands this supplies the extra digit.
        if (ops_full) begin
          acc   <= '0;
          xs    <= XS_W'(x);
          xprev <= 1'b0;
          cnt   <= '0;
        end
      end else if (state == CALC) begin
        acc   <= acc_step;
        xs    <= xs >> 2;
        xprev <= xs[1];
        cnt   <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_assume_r4_mult.sv
// Self-checking bench for assume_r4_mult: byte-level behavioural model plus directed literal checks.
module tb_assume_r4_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        getA = 1'b0;
  logic        getX = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [31:0] result;
  logic        ready;

  int nChecks = 0;
  int nFail   = 0;
  bit chkEn   = 1'b0;

`ifdef ASSUME_R4_SIGNED_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 10;
`endif

  assume_r4_mult dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .getA   (getA),
    .getX   (getX),
    .in     (din),
    .result (result),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] product(input logic [15:0] pa, input logic [15:0] px);
`ifdef ASSUME_R4_SIGNED_EN
    int sa;
    int sx;
    sa = $signed(pa);
    sx = $signed(px);
    return 32'(sa * sx);
`else
    logic [31:0] ua;
    logic [31:0] ux;
    ua = {16'h0000, pa};
    ux = {16'h0000, px};
    return ua * ux;
`endif
  endfunction

  // Behavioural model: counts captured bytes, then a fixed latency later the product appears.
  logic [15:0] mA = '0, mX = '0;
  int          nA = 0, nX = 0, countdown = -1;
  bit          prevA = 0, prevX = 0, armed = 0, riseA, riseX;
  logic        mReady = 1'b0;
  logic [31:0] mResult = '0;

  always @(posedge clk) begin
    if (rst) begin
      mA = '0; mX = '0; nA = 0; nX = 0; prevA = 0; prevX = 0;
      armed = 0; countdown = -1; mReady = 1'b0; mResult = '0;
    end else begin
      riseA = getA && !prevA;
      riseX = getX && !prevX;
      prevA = getA;
      prevX = getX;
      if (start) begin
        mA = '0; mX = '0; nA = 0; nX = 0;
        armed = 1; countdown = -1; mReady = 1'b0; mResult = '0;
      end else if (armed && countdown < 0) begin
        if (riseA && nA < 2) begin mA = mA | (16'(din) << (8 * nA)); nA++; end
        if (riseX && nX < 2) begin mX = mX | (16'(din) << (8 * nX)); nX++; end
        if (nA == 2 && nX == 2) countdown = LAT;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          mReady  = 1'b1;
          mResult = product(mA, mX);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      nChecks++;
      if (ready !== mReady) begin
        nFail++;
        $display("[TB] FAIL model_ready: got %b expected %b at %0t", ready, mReady, $time);
      end
      nChecks++;
      if (result !== mResult) begin
        nFail++;
        $display("[TB] FAIL model_result: got %h expected %h at %0t", result, mResult, $time);
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic ga, input logic gx, input logic [7:0] d);
    start = s;
    getA  = ga;
    getX  = gx;
    din   = d;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expRes, input logic expRdy);
    nChecks++;
    if (result !== expRes || ready !== expRdy) begin
      nFail++;
      $display("[TB] FAIL %s: got result=%h ready=%b expected result=%h ready=%b",
               name, result, ready, expRes, expRdy);
    end
    nChecks++;
    if (mResult !== expRes) begin
      nFail++;
      $display("[TB] FAIL %s_model: got %h expected %h", name, mResult, expRes);
    end
  endtask

  // Start, then A low/high and X low/high; returns right after the final byte is captured.
  task automatic loadOperands(input logic [15:0] a, input logic [15:0] x);
    applyStimulus(1, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, a[7:0]);
    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, a[15:8]);
    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(0, 0, 1, x[7:0]);
    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(0, 0, 1, x[15:8]);
  endtask

  task automatic waitLatency(input string name, input bit noise);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      if (noise) applyStimulus(0, n[0], ~n[0], 8'hFF);
      else       applyStimulus(0, 0, 0, 8'h00);
      n++;
    end
    if (noise) applyStimulus(0, 0, 0, 8'h00);
    nChecks++;
    if (n != LAT) begin
      nFail++;
      $display("[TB] FAIL %s_latency: got %0d cycles expected %0d", name, n, LAT);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(0, 0, 0, 8'h00);
    chkEn = 1'b1;
    checkOutput("reset", 32'h0, 1'b0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 8'h00);
    checkOutput("idle", 32'h0, 1'b0);

    loadOperands(16'hFFFB, 16'h0008);
    waitLatency("m5x8", 0);
`ifdef ASSUME_R4_SIGNED_EN
    checkOutput("m5x8", 32'hFFFFFFD8, 1'b1);
`else
    checkOutput("m5x8", 32'h0007FFD8, 1'b1);
`endif

    applyStimulus(1, 0, 0, 8'h00);
    checkOutput("start_in_done", 32'h0, 1'b0);
    loadOperands(16'h7FFF, 16'h7FFF);
    waitLatency("max_pos", 1);
    checkOutput("max_pos", 32'h3FFF0001, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(0, i[0], ~i[0], 8'hAA);
    applyStimulus(0, 0, 0, 8'h00);
    checkOutput("done_hold", 32'h3FFF0001, 1'b1);

    loadOperands(16'h8000, 16'h8000);
    waitLatency("min_neg", 0);
    checkOutput("min_neg", 32'h40000000, 1'b1);

    loadOperands(16'hFFFF, 16'hFFFF);
    waitLatency("all_ones", 0);
`ifdef ASSUME_R4_SIGNED_EN
    checkOutput("all_ones", 32'h00000001, 1'b1);
`else
    checkOutput("all_ones", 32'hFFFE0001, 1'b1);
`endif

    // Held strobe loads once; third getA rise ignored; simultaneous rise loads X high only.
    applyStimulus(1, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 8'h34);
    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(0, 1, 1, 8'h12);
    waitLatency("held_x", 0);
    checkOutput("held_x", 32'h0, 1'b1);

    applyStimulus(1, 0, 0, 8'h00);
    applyStimulus(0, 1, 1, 8'h03);
    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(0, 1, 1, 8'h00);
    waitLatency("both_rise", 0);
    checkOutput("both_rise", 32'h00000009, 1'b1);

    applyStimulus(1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 8'h02);
    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(0, 0, 1, 8'h05);
    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(0, 0, 1, 8'h00);
    waitLatency("held_a", 0);
    checkOutput("held_a", 32'h0000000A, 1'b1);

    loadOperands(16'h1111, 16'h2222);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'h00);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 8'h00);
    rst = 1'b0;
    checkOutput("rst_calc", 32'h0, 1'b0);
    for (int i = 0; i < 14; i++) applyStimulus(0, i[0], i[1], 8'h55);
    checkOutput("idle_hold", 32'h0, 1'b0);

    rst = 1'b1;
    applyStimulus(1, 0, 0, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(0, i[0], i[0], 8'h07);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 8'h00);
    checkOutput("rst_priority", 32'h0, 1'b0);

    loadOperands(16'h0003, 16'h0005);
    waitLatency("after_rst", 0);
    checkOutput("after_rst", 32'h0000000F, 1'b1);

    chkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
